// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types, defaults and checksum helper for the program loader
package prog_loader_pkg;

    localparam int DEF_WORD     = 8;
    localparam int DEF_SIZE_LOG = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_WSTB  = 3'd2,
        ST_WHOLD = 3'd3,
        ST_RSTB  = 3'd4,
        ST_RNEXT = 3'd5,
        ST_DONE  = 3'd6
    } loader_state_t;

    // Modular add; width is a runtime argument so one helper serves any WORD.
    function automatic logic [31:0] csum_add(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int          width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (a + b) & mask;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - word stream and program-memory bus of the program loader
// master: the loader (consumes the stream, drives the memory strobes)
// slave : the environment (stream source plus program memory)
interface prog_loader_if #(
    parameter int WORD     = prog_loader_pkg::DEF_WORD,
    parameter int SIZE_LOG = prog_loader_pkg::DEF_SIZE_LOG
);
    logic                in_valid;
    logic [WORD-1:0]     in_data;
    logic                in_ready;
    logic                mem_read;
    logic                mem_write;
    logic [SIZE_LOG-1:0] mem_address;
    logic [WORD-1:0]     mem_data_in;
    logic [WORD-1:0]     mem_data_out;

    modport master (
        input  in_valid, in_data, mem_data_out,
        output in_ready, mem_read, mem_write, mem_address, mem_data_in
    );

    modport slave (
        output in_valid, in_data, mem_data_out,
        input  in_ready, mem_read, mem_write, mem_address, mem_data_in
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a program image into the latch memory and verifies it by checksum
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, load_len   begin a load of min(load_len, SIZE) words (sampled in IDLE)
//   bus (master)      word stream in (valid/ready), memory read/write/address/data
//   busy, done        not idle; one-cycle end-of-load pulse
//   error             sticky read-back checksum mismatch, cleared by the next start
//   checksum          running sum of written words mod 2**WORD
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int WORD     = DEF_WORD,
    parameter int SIZE_LOG = DEF_SIZE_LOG,
    parameter int SIZE     = 2**SIZE_LOG
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [SIZE_LOG:0]   load_len,
    prog_loader_if.master       bus,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [WORD-1:0]     checksum
);

    loader_state_t       r_state;
    logic [SIZE_LOG:0]   r_len;
    logic [SIZE_LOG:0]   r_addr;      // one extra bit so len = SIZE terminates
    logic [WORD-1:0]     r_wsum;
    logic [WORD-1:0]     r_rsum;
    logic [WORD-1:0]     r_data;
    logic                r_in_ready;
    logic                r_mem_read;
    logic                r_mem_write;
    logic                r_busy;
    logic                r_done;
    logic                r_error;

    logic [SIZE_LOG:0]   w_len_clamped;
    logic [SIZE_LOG:0]   w_addr_next;
    logic                w_last;

    assign w_len_clamped = (load_len > (SIZE_LOG+1)'(SIZE)) ? (SIZE_LOG+1)'(SIZE) : load_len;
    assign w_addr_next   = r_addr + 1'b1;
    assign w_last        = (w_addr_next == r_len);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_addr      <= '0;
            r_wsum      <= '0;
            r_rsum      <= '0;
            r_data      <= '0;
            r_in_ready  <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_len   <= w_len_clamped;
                        r_addr  <= '0;
                        r_wsum  <= '0;
                        r_rsum  <= '0;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        if (w_len_clamped == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= ST_WAIT;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_data      <= bus.in_data;
                        r_wsum      <= WORD'(csum_add(32'(r_wsum), 32'(bus.in_data), WORD));
                        r_in_ready  <= 1'b0;
                        r_mem_write <= 1'b1;
                        r_state     <= ST_WSTB;
                    end
                end
                ST_WSTB: begin
                    r_mem_write <= 1'b0;
                    r_state     <= ST_WHOLD;
                end
                ST_WHOLD: begin
                    // Address moves only here, one cycle after write has dropped.
                    if (w_last) begin
                        r_addr     <= '0;
                        r_mem_read <= 1'b1;
                        r_state    <= ST_RSTB;
                    end else begin
                        r_addr     <= w_addr_next;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_RSTB: begin
                    r_rsum     <= WORD'(csum_add(32'(r_rsum), 32'(bus.mem_data_out), WORD));
                    r_mem_read <= 1'b0;
                    r_state    <= ST_RNEXT;
                end
                ST_RNEXT: begin
                    r_addr <= w_addr_next;
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_error <= (r_rsum != r_wsum);
                        r_state <= ST_DONE;
                    end else begin
                        r_mem_read <= 1'b1;
                        r_state    <= ST_RSTB;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_address = r_addr[SIZE_LOG-1:0];
    assign bus.mem_data_in = r_data;
    assign busy            = r_busy;
    assign done            = r_done;
    assign error           = r_error;
    assign checksum        = r_wsum;

endmodule
